// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the iterative square / square-root blocks:
// FSM state encodings, default operand width and counter sizing.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WORK = 1'b1;

  // One extra bit so the step counter can reach WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/square_seq_if.sv
// Start/busy handshake bundle shared by the square and square-root blocks.
// The controller drives the master side; the arithmetic block is the slave.
interface square_seq_if #(
  parameter int WIDTH = arith_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0]   x_bi;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] y_bo;

  modport master (
    output x_bi, start_i,
    input  busy_o, done_o, y_bo
  );

  modport slave (
    input  x_bi, start_i,
    output busy_o, done_o, y_bo
  );

endinterface

// File: rtl/square_seq.sv
// Sequential squarer y = x*x: radix-2 shift-add, one partial product per clock.
// Operand is captured on an accepted start; the result lands with a one-cycle done pulse.
module square_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_i,
  square_seq_if.slave sq
);

  localparam int CW = cnt_width(WIDTH);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   x_shr;
  logic [2*WIDTH-1:0] x_ext;
  logic [2*WIDTH-1:0] sum;
  logic               last;

  // Current partial product is folded into the sum combinationally, so the
  // last step can write y directly instead of waiting one more cycle.
  assign x_shr = x_q >> cnt_q;
  assign x_ext = {{WIDTH{1'b0}}, x_q};
  assign sum   = x_shr[0] ? acc_q + (x_ext << cnt_q) : acc_q;
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sq.start_i) begin
          x_d     = sq.x_bi;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = WORK;
        end
      end
      WORK: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          y_d     = sum;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign sq.busy_o = state_q[0];
  assign sq.done_o = done_q;
  assign sq.y_bo   = y_q;

endmodule

// File: doc/square_seq.md
Name: square_seq

Overview:
Sequential integer squarer, the inverse of the team's 8-bit iterative square root: y_bo = x_bi * x_bi.
Radix-2 shift-add, one partial product per clock, with the same start/busy handshake as the root block so the two can share a controller.
Used to check root results (y*y <= x < (y+1)^2) and in datapaths that need x^2 without a hard multiplier.

Parameters:
WIDTH, 8, operand width in bits; WIDTH >= 2; result width is 2*WIDTH.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  reset; asynchronous, active-high.
x_bi  input  WIDTH  unsigned operand; sampled only on an accepted start.
start_i  input  1  request; accepted only when in IDLE.
busy_o  output  1  high while computing (state == WORK).
done_o  output  1  one-cycle pulse when y_bo is updated.
y_bo  output  2*WIDTH  unsigned result; holds its value until the next completion.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, busy_o=0, done_o=0, y_bo=0, acc=0, cnt=0, x_reg=0. Takes effect immediately and overrides everything. Reset mid-WORK abandons the operation; y_bo does not update.
- States, 1-bit encoding: IDLE=0, WORK=1. busy_o is the state bit directly (registered, no combinational path from start_i).
- IDLE, start_i=1 at an edge:
  - x_reg<=x_bi, acc<=0, cnt<=0, state<=WORK.
  - y_bo is unchanged.
- IDLE, start_i=0: hold all state.
- WORK, every edge:
  - if x_reg[cnt]: acc <= acc + (x_reg << cnt), zero-extended to 2*WIDTH.
  - cnt <= cnt+1.
  - cnt is $clog2(WIDTH)+1 bits wide, so it cannot wrap within an operation.
- WORK edge where cnt == WIDTH-1 (last partial product):
  - y_bo <= final sum, i.e. acc plus the last partial product. The final partial product must be folded in on this edge, not one cycle later.
  - done_o<=1, state<=IDLE.
- done_o is 0 on every other edge.
- Latency:
  - start sampled at edge E0; busy_o is high from E0 for exactly WIDTH cycles.
  - y_bo and done_o change at edge E0+WIDTH, the same edge at which busy_o falls.
  - Back-to-back start: start_i held high is accepted on the first IDLE edge, so throughput is WIDTH+1 cycles per operation.
- start_i during WORK: ignored, not queued.
- x_bi changes during WORK: ignored; x_reg is frozen.
- Width rules:
  - The accumulator is 2*WIDTH bits and never overflows; max result is (2^WIDTH-1)^2.
  - Sum width is 2*WIDTH; no carry-out is needed.
- No X propagation: all registers are reset, including x_reg and acc.

Decomposition:
- Shared package arith_pkg holds:
  - state localparams IDLE/WORK, shared with the root block;
  - the default WIDTH constant;
  - the cnt-width function.
- No sub-module. The conditional shift-add is a single expression. A separate adder module adds nothing.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> outputs go to busy_o=0, y_bo=0, done_o=0 before the next edge. Start x=13, reset at cycle 3 of WORK -> y_bo stays 0, busy_o=0, no done_o.
- Basic values (WIDTH=8): x=0->0, 1->1, 2->4, 13->169, 128->16384, 255->65025.
  - busy_o high exactly 8 cycles.
  - done_o one pulse on the edge busy_o falls.
- Handshake:
  - start_i held high across a full op with x=3 then x=5 -> results 9 then 25; second accept is 9 cycles after the first.
  - Toggling start_i and x_bi during WORK -> result unchanged.
- Hold: after x=200 -> y_bo=40000 persists for 20 idle cycles; done_o stays 0.
- Exhaustive round trip: for all x in 0..255 -> y_bo==x*x. Feed y_bo>>8 patterns, chaining floor-root results r of the root block -> square_seq(r) <= x < square_seq(r+1).
- Parameter: WIDTH=4, x=15 -> 225 after 4 busy cycles. WIDTH=16, x=65535 -> 4294836225.
